// File: rtl/lut_neuron_loadable.sv
// Runtime-loadable LUT neuron: a full IN_BITS->OUT_BITS truth table streamed in
// over a valid/ready config bus, served as one-cycle registered lookups.

// One column of the table: holds entry j of every beat, so a whole beat is a
// single-row write across all banks and a lookup is one row read per bank.
module lut_bank #(
  parameter int ROWS     = 16,
  parameter int OUT_BITS = 2,
  localparam int RW      = $clog2(ROWS)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [RW-1:0]       waddr,
  input  logic [OUT_BITS-1:0] wdata,
  input  logic [RW-1:0]       raddr,
  output logic [OUT_BITS-1:0] rdata
);
  logic [OUT_BITS-1:0] mem [ROWS];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

module lut_neuron_loadable #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 2,
  parameter int WR_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [WR_WIDTH-1:0] cfg_data,
  input  logic                cfg_last,
  input  logic                err_clr,
  output logic                loaded,
  output logic                err,
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data
);
  localparam int EPB    = WR_WIDTH / OUT_BITS;
  localparam int NBEATS = (1 << IN_BITS) / EPB;
  localparam int PW     = $clog2(NBEATS);
  localparam int LW     = $clog2(EPB);
  localparam int STAGES = 1;

  typedef enum logic [1:0] {S_EMPTY, S_LOADING, S_READY, S_ERROR} state_t;

  typedef struct packed {
    logic               vld;
    logic [IN_BITS-1:0] addr;
  } lk_req_t;

  state_t              state, state_nxt;
  logic [PW-1:0]       ptr, ptr_nxt;
  logic                we;
  logic                acc;
  lk_req_t             req;
  logic [STAGES:0]     vld_pipe;
  logic [EPB-1:0][OUT_BITS-1:0] bank_rd;

  assign acc = cfg_valid && cfg_ready;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_EMPTY;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end

  // Framing errors never write the offending beat.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    we        = 1'b0;
    case (state)
      S_EMPTY, S_READY:
        if (acc) begin
          if (cfg_last) begin
            state_nxt = S_ERROR;
          end else begin
            we        = 1'b1;
            ptr_nxt   = PW'(1);
            state_nxt = S_LOADING;
          end
        end
      S_LOADING:
        if (acc) begin
          if (ptr == PW'(NBEATS - 1)) begin
            if (cfg_last) begin
              we        = 1'b1;
              ptr_nxt   = '0;
              state_nxt = S_READY;
            end else begin
              state_nxt = S_ERROR;
            end
          end else if (cfg_last) begin
            state_nxt = S_ERROR;
          end else begin
            we      = 1'b1;
            ptr_nxt = ptr + PW'(1);
          end
        end
      S_ERROR:
        if (err_clr) begin
          state_nxt = S_EMPTY;
          ptr_nxt   = '0;
        end
      default: state_nxt = S_EMPTY;
    endcase
  end

  assign cfg_ready = (state != S_ERROR);
  assign loaded    = (state == S_READY);
  assign err       = (state == S_ERROR);

  // Bank j holds entry j of each beat; ptr is 0 whenever a beat-0 write occurs.
  for (genvar j = 0; j < EPB; j++) begin : g_bank
    lut_bank #(.ROWS(NBEATS), .OUT_BITS(OUT_BITS)) u_bank (
      .clk   (clk),
      .we    (we),
      .waddr (ptr),
      .wdata (cfg_data[OUT_BITS*j +: OUT_BITS]),
      .raddr (in_data[IN_BITS-1:LW]),
      .rdata (bank_rd[j])
    );
  end

  // A reload write lands on the same edge as the read, so READY lookups see the old table.
  assign req         = '{vld: in_valid && (state == S_READY), addr: in_data};
  assign vld_pipe[0] = req.vld;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_pipe[STAGES:1] <= '0;
      out_data           <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (req.vld) out_data <= bank_rd[req.addr[LW-1:0]];
    end

  assign out_valid = vld_pipe[STAGES];
endmodule

// File: doc/lut_neuron_loadable.md
Name: lut_neuron_loadable

Overview:
- Runtime-programmable LUT neuron: holds the full truth table of one quantised neuron (IN_BITS-bit concatenated input code → OUT_BITS-bit output code) in distributed RAM.
- Answers lookups with a registered one-cycle latency.
- This is the writer/loader counterpart to the fixed-ROM neuron layers. Retrained HGCAL encoder/decoder tables can be streamed in from the config bus without re-synthesis.
- Sits between the config DMA/AXI-lite shim and the layer datapath.

Parameters:
- IN_BITS, 8: lookup address width; table depth = 2^IN_BITS = 256 entries.
- OUT_BITS, 2: bits per table entry.
- WR_WIDTH, 32: config beat width; must be a multiple of OUT_BITS. EPB = WR_WIDTH/OUT_BITS = 16 entries per beat.
- NBEATS, 2^IN_BITS/EPB = 16: beats per full table (derived, not overridable).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  config beat valid.
- cfg_ready  out  1  config beat accept; a beat transfers when cfg_valid && cfg_ready.
- cfg_data  in  WR_WIDTH  packed entries. Entry j of beat k sits at bits [OUT_BITS*j+OUT_BITS-1 : OUT_BITS*j] and has address k*EPB+j.
- cfg_last  in  1  marks the final beat of a table.
- err_clr  in  1  single-cycle pulse; clears the error state.
- loaded  out  1  table valid; lookups are being served.
- err  out  1  sticky framing error.
- in_valid  in  1  lookup request.
- in_data  in  IN_BITS  lookup address (raw concatenated input code).
- out_valid  out  1  lookup result valid.
- out_data  out  OUT_BITS  table[in_data] from the previous cycle.

Behaviour:
- Reset values, async on rst_n low: state=EMPTY, beat pointer=0, loaded=0, err=0, out_valid=0, out_data=0, cfg_ready=1.
- Table RAM contents are not reset; they are undefined until the first full load.
- States:
  - EMPTY: cfg_ready=1, loaded=0.
  - LOADING: cfg_ready=1, loaded=0.
  - READY: cfg_ready=1, loaded=1.
  - ERROR: cfg_ready=0, loaded=0, err=1.
- Load transfer: each accepted beat writes EPB entries at beat pointer ptr, then ptr increments. ptr is $clog2(NBEATS) bits wide.
- EMPTY or READY + accepted beat → write beat 0, ptr=1, go to LOADING. loaded falls the cycle after acceptance.
  - A 1-beat table is impossible, so if cfg_last=1 on that beat → ERROR.
- LOADING + accepted beat with ptr<NBEATS-1:
  - cfg_last=0 → write, increment.
  - cfg_last=1 → ERROR (early last). The beat is not written.
- LOADING + accepted beat with ptr==NBEATS-1:
  - cfg_last=1 → write, ptr=0, go to READY. loaded=1 from the next cycle.
  - cfg_last=0 → ERROR (missing last). The beat is not written.
- ERROR: holds until an err_clr pulse, then goes to EMPTY with ptr=0 and err=0 on the next cycle. err_clr in any other state has no effect.
- Lookup: out_valid(t+1) = in_valid(t) && (state==READY at t); out_data(t+1) = table[in_data(t)].
  - When out_valid=0, out_data holds its last value.
  - Throughput is one lookup per cycle; there is no backpressure.
  - Lookups outside READY are dropped silently and do not set err.
- Simultaneous events:
  - The final load beat and in_valid in the same cycle: the lookup is dropped, because state is still LOADING at that edge.
  - A reload beat accepted in READY together with in_valid: the lookup is served from the old table, since the write lands at the same edge.
- Reset mid-load: state returns to EMPTY and ptr=0. Partially written entries remain but are unusable until a complete reload.

Test Plan:
- Reset release → loaded=0, err=0, cfg_ready=1, out_valid=0. in_valid=1 with in_data=8'h00 gives out_valid=0.
- Stream 16 beats of 32'hE4E4E4E4 (entries 0,1,2,3 repeating), cfg_last on beat 15 → loaded=1 one cycle after beat 15.
  - Lookup 8'h06 → out_data=2'b10 one cycle later.
  - Lookup 8'hFF → 2'b11.
- Back-to-back lookups 8'h00..8'hFF on consecutive cycles after the load above → 256 consecutive out_valid pulses, out_data = addr[1:0], latency exactly 1.
- cfg_last on beat 3 → err=1, cfg_ready=0, loaded=0. Further cfg_valid beats are not accepted. err_clr pulse → err=0, cfg_ready=1, state EMPTY.
- 16 beats with cfg_last low on beat 15 → err=1 after beat 15; the table is not marked loaded.
- Full load, then 7 beats of a reload (32'h00000000), then rst_n low for 2 cycles → loaded=0.
  - A fresh 16-beat load of 32'h55555555 → every lookup returns 2'b01.
